ckn_ad_store: RTL and testbench

Upstream neighbour of the write-request stage. Accepts per-frame headers (decrypt/hash flags, CKN/AD word count) and the CKN/AD word stream from the read path. Buffers the words in a 33-bit FIFO, with bit 32 marking the last word of each frame, and the headers in a 10-bit info FIFO. Raises a one-shot write trigger per job so the write-request stage can start draining.

---
 rtl/ckn_ad_pkg.sv | 19 +
 rtl/sync_fifo.sv | 83 ++++++++
 rtl/ckn_ad_store.sv | 153 +++++++++++++++
 tb/tb_ckn_ad_store.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ckn_ad_pkg.sv
// Shared types and field positions for the CKN/AD store.
package ckn_ad_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HDR   = 2'd1,
      S_WORDS = 2'd2
   } state_e;

   localparam int unsigned CKN_W         = 33;
   localparam int unsigned INFO_W        = 10;
   localparam int unsigned LAST_BIT      = 32;
   localparam int unsigned INFO_DEC_BIT  = 9;
   localparam int unsigned INFO_HASH_BIT = 8;
   localparam int unsigned WORD_W        = 32;
   localparam int unsigned LEN_W         = 32;
   localparam int unsigned WCNT_W        = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data (one-cycle read latency) and
// registered full/empty flags. Pops on empty and pushes on full are dropped.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         pop_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push_i & ~full_q;
   assign pop_ok  = pop_i & ~empty_q;

   // Pointer, occupancy and read-data update; flags follow the next count.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      data_d   = data_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         data_d   = mem_q[rd_ptr_q];
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == '0);
   end

   // Control state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         data_q   <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         data_q   <= data_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage array; contents are only observed through valid pops.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign pop_data_o = data_q;
   assign full_o     = full_q;
   assign empty_o    = empty_q;
   assign count_o    = count_q;

endmodule

// File: rtl/ckn_ad_store.sv
// Buffers per-frame headers and CKN/AD words for the write-request stage and
// raises one write trigger per job once its first word is buffered.
module ckn_ad_store
   import ckn_ad_pkg::*;
#(
   parameter int unsigned CKN_DEPTH  = 64,
   parameter int unsigned INFO_DEPTH = 8
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              start_i,
   input  logic [31:0]       length_i,
   input  logic              hdr_vld_i,
   output logic              hdr_rdy_o,
   input  logic              hdr_dec_i,
   input  logic              hdr_hash_i,
   input  logic [7:0]        hdr_words_i,
   input  logic              word_vld_i,
   output logic              word_rdy_o,
   input  logic [31:0]       word_i,
   output logic [32:0]       ckn_data_o,
   output logic              ckn_ad_avail_o,
   input  logic              ckn_ad_fetch_i,
   output logic [9:0]        wr_info_o,
   output logic              wr_info_avail_o,
   input  logic              wr_info_req_i,
   output logic              wr_trigger_o,
   output logic              busy_o,
   output logic              err_o
);

   state_e              state_q, state_d;
   logic [LEN_W-1:0]    length_q, length_d;
   logic [LEN_W-1:0]    frame_cnt_q, frame_cnt_d;
   logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
   logic                armed_q, armed_d;
   logic                trig_q, trig_d;
   logic                err_q, err_d;

   logic                ckn_full, ckn_empty;
   logic                info_full, info_empty;
   logic [$clog2(CKN_DEPTH):0]  ckn_cnt;
   logic [$clog2(INFO_DEPTH):0] info_cnt;
   logic                hdr_hs, word_hs;
   logic                pop_empty;
   logic [CKN_W-1:0]    ckn_push_data;
   logic [INFO_W-1:0]   info_push_data;

   assign hdr_rdy_o  = (state_q == S_HDR) & ~info_full;
   assign word_rdy_o = (state_q == S_WORDS) & ~ckn_full;
   assign hdr_hs     = hdr_vld_i & hdr_rdy_o;
   assign word_hs    = word_vld_i & word_rdy_o;
   assign pop_empty  = (ckn_ad_fetch_i & (ckn_cnt == '0)) |
                       (wr_info_req_i & (info_cnt == '0));

   assign ckn_push_data  = {(word_cnt_q == '0), word_i};
   assign info_push_data = {hdr_dec_i, hdr_hash_i, hdr_words_i};

   // Job sequencing: header, then its words, until the frame count is reached.
   always_comb begin
      state_d     = state_q;
      length_d    = length_q;
      frame_cnt_d = frame_cnt_q;
      word_cnt_d  = word_cnt_q;
      armed_d     = armed_q;
      trig_d      = 1'b0;
      err_d       = err_q | pop_empty;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               length_d    = length_i;
               frame_cnt_d = '0;
               err_d       = pop_empty;
               armed_d     = 1'b1;
               state_d     = S_HDR;
            end
         end
         S_HDR: begin
            if (hdr_hs) begin
               word_cnt_d = hdr_words_i;
               state_d    = S_WORDS;
            end
         end
         S_WORDS: begin
            if (word_hs) begin
               if (armed_q) begin
                  trig_d  = 1'b1;
                  armed_d = 1'b0;
               end
               if (word_cnt_q == '0) begin
                  frame_cnt_d = frame_cnt_q + LEN_W'(1);
                  state_d     = (frame_cnt_q + LEN_W'(1) == length_q) ? S_IDLE : S_HDR;
               end else begin
                  word_cnt_d = word_cnt_q - WCNT_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Sequencer state registers.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q     <= S_IDLE;
         length_q    <= '0;
         frame_cnt_q <= '0;
         word_cnt_q  <= '0;
         armed_q     <= 1'b0;
         trig_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         length_q    <= length_d;
         frame_cnt_q <= frame_cnt_d;
         word_cnt_q  <= word_cnt_d;
         armed_q     <= armed_d;
         trig_q      <= trig_d;
         err_q       <= err_d;
      end
   end

   sync_fifo #(.WIDTH(CKN_W), .DEPTH(CKN_DEPTH)) u_ckn_fifo (
      .clk         (iClk),
      .rst         (iRst),
      .push_i      (word_hs),
      .push_data_i (ckn_push_data),
      .pop_i       (ckn_ad_fetch_i),
      .pop_data_o  (ckn_data_o),
      .full_o      (ckn_full),
      .empty_o     (ckn_empty),
      .count_o     (ckn_cnt)
   );

   sync_fifo #(.WIDTH(INFO_W), .DEPTH(INFO_DEPTH)) u_info_fifo (
      .clk         (iClk),
      .rst         (iRst),
      .push_i      (hdr_hs),
      .push_data_i (info_push_data),
      .pop_i       (wr_info_req_i),
      .pop_data_o  (wr_info_o),
      .full_o      (info_full),
      .empty_o     (info_empty),
      .count_o     (info_cnt)
   );

   assign ckn_ad_avail_o  = ~ckn_empty;
   assign wr_info_avail_o = ~info_empty;
   assign wr_trigger_o    = trig_q;
   assign busy_o          = (state_q != S_IDLE);
   assign err_o           = err_q;

endmodule

// File: tb/tb_ckn_ad_store.sv
// Directed bench for ckn_ad_store with hand-computed expectations.
module tb_ckn_ad_store;

   logic        iClk;
   logic        iRst;
   logic        start_i;
   logic [31:0] length_i;
   logic        hdr_vld_i;
   logic        hdr_rdy_o;
   logic        hdr_dec_i;
   logic        hdr_hash_i;
   logic [7:0]  hdr_words_i;
   logic        word_vld_i;
   logic        word_rdy_o;
   logic [31:0] word_i;
   logic [32:0] ckn_data_o;
   logic        ckn_ad_avail_o;
   logic        ckn_ad_fetch_i;
   logic [9:0]  wr_info_o;
   logic        wr_info_avail_o;
   logic        wr_info_req_i;
   logic        wr_trigger_o;
   logic        busy_o;
   logic        err_o;

   int checks   = 0;
   int failures = 0;
   int trig_cnt = 0;

   ckn_ad_store #(.CKN_DEPTH(64), .INFO_DEPTH(8)) dut (
      .iClk            (iClk),
      .iRst            (iRst),
      .start_i         (start_i),
      .length_i        (length_i),
      .hdr_vld_i       (hdr_vld_i),
      .hdr_rdy_o       (hdr_rdy_o),
      .hdr_dec_i       (hdr_dec_i),
      .hdr_hash_i      (hdr_hash_i),
      .hdr_words_i     (hdr_words_i),
      .word_vld_i      (word_vld_i),
      .word_rdy_o      (word_rdy_o),
      .word_i          (word_i),
      .ckn_data_o      (ckn_data_o),
      .ckn_ad_avail_o  (ckn_ad_avail_o),
      .ckn_ad_fetch_i  (ckn_ad_fetch_i),
      .wr_info_o       (wr_info_o),
      .wr_info_avail_o (wr_info_avail_o),
      .wr_info_req_i   (wr_info_req_i),
      .wr_trigger_o    (wr_trigger_o),
      .busy_o          (busy_o),
      .err_o           (err_o)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   // Count trigger pulses away from the active edge.
   always @(negedge iClk) if (wr_trigger_o === 1'b1) trig_cnt++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic do_start(input logic [31:0] len);
      start_i  = 1'b1;
      length_i = len;
      tick();
      start_i  = 1'b0;
   endtask

   task automatic send_hdr(input logic dec, input logic hash, input logic [7:0] words);
      int n = 0;
      hdr_vld_i   = 1'b1;
      hdr_dec_i   = dec;
      hdr_hash_i  = hash;
      hdr_words_i = words;
      while (hdr_rdy_o !== 1'b1 && n < 200) begin tick(); n++; end
      chk("hdr_wait", 64'(hdr_rdy_o), 64'd1);
      tick();
      hdr_vld_i = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      int n = 0;
      word_vld_i = 1'b1;
      word_i     = w;
      while (word_rdy_o !== 1'b1 && n < 200) begin tick(); n++; end
      chk("word_wait", 64'(word_rdy_o), 64'd1);
      tick();
      word_vld_i = 1'b0;
   endtask

   task automatic pop_ckn(input string tag, input logic [32:0] exp);
      ckn_ad_fetch_i = 1'b1;
      tick();
      ckn_ad_fetch_i = 1'b0;
      chk(tag, 64'(ckn_data_o), 64'(exp));
   endtask

   task automatic pop_info(input string tag, input logic [9:0] exp);
      wr_info_req_i = 1'b1;
      tick();
      wr_info_req_i = 1'b0;
      chk(tag, 64'(wr_info_o), 64'(exp));
   endtask

   initial begin
      logic [32:0] exp2 [7];
      logic [32:0] q [$];
      logic [32:0] e;
      int          pushed;
      int          cyc;
      int          maxocc;
      int          tc0;
      logic        do_push;
      logic        do_pop;

      iRst = 1'b1; start_i = 1'b0; length_i = '0;
      hdr_vld_i = 1'b0; hdr_dec_i = 1'b0; hdr_hash_i = 1'b0; hdr_words_i = '0;
      word_vld_i = 1'b0; word_i = '0; ckn_ad_fetch_i = 1'b0; wr_info_req_i = 1'b0;

      // Reset state
      tick(); tick(); tick();
      chk("rst_ckn_data", 64'(ckn_data_o), 64'd0);
      chk("rst_info", 64'(wr_info_o), 64'd0);
      chk("rst_avail", 64'({ckn_ad_avail_o, wr_info_avail_o}), 64'd0);
      chk("rst_rdy", 64'({hdr_rdy_o, word_rdy_o}), 64'd0);
      chk("rst_trig_busy_err", 64'({wr_trigger_o, busy_o, err_o}), 64'd0);
      iRst = 1'b0;
      tick();

      // Single frame, 3 words; a start in mid-job is ignored
      do_start(32'd1);
      chk("t1_busy", 64'(busy_o), 64'd1);
      send_hdr(1'b0, 1'b0, 8'd2);
      start_i = 1'b1; length_i = 32'd5; tick(); start_i = 1'b0;
      send_word(32'hAAAA_0001);
      send_word(32'hBBBB_0002);
      send_word(32'hCCCC_0003);
      chk("t1_busy_done", 64'(busy_o), 64'd0);
      tick();
      chk("t1_trig", 64'(trig_cnt), 64'd1);
      chk("t1_avail", 64'({ckn_ad_avail_o, wr_info_avail_o}), 64'd3);
      pop_info("t1_info", 10'h002);
      pop_ckn("t1_w0", {1'b0, 32'hAAAA_0001});
      pop_ckn("t1_w1", {1'b0, 32'hBBBB_0002});
      pop_ckn("t1_w2", {1'b1, 32'hCCCC_0003});
      chk("t1_empty", 64'({ckn_ad_avail_o, wr_info_avail_o}), 64'd0);
      chk("t1_err", 64'(err_o), 64'd0);

      // Three frames of 1, 4 and 2 words
      exp2 = '{{1'b1, 32'hB000_0000}, {1'b0, 32'hB000_0001}, {1'b0, 32'hB000_0002},
               {1'b0, 32'hB000_0003}, {1'b1, 32'hB000_0004}, {1'b0, 32'hB000_0005},
               {1'b1, 32'hB000_0006}};
      do_start(32'd3);
      send_hdr(1'b0, 1'b0, 8'd0);
      send_word(32'hB000_0000);
      chk("t2_busy_mid", 64'(busy_o), 64'd1);
      send_hdr(1'b0, 1'b0, 8'd3);
      for (int k = 1; k <= 4; k++) send_word(32'hB000_0000 + 32'(k));
      send_hdr(1'b0, 1'b0, 8'd1);
      send_word(32'hB000_0005);
      send_word(32'hB000_0006);
      chk("t2_busy_done", 64'(busy_o), 64'd0);
      tick();
      chk("t2_trig", 64'(trig_cnt), 64'd2);
      pop_info("t2_info0", 10'h000);
      pop_info("t2_info1", 10'h003);
      pop_info("t2_info2", 10'h001);
      for (int k = 0; k < 7; k++) pop_ckn("t2_word", exp2[k]);
      chk("t2_empty", 64'(ckn_ad_avail_o), 64'd0);

      // Backpressure: 70-word frame into a 64-deep FIFO
      do_start(32'd1);
      send_hdr(1'b1, 1'b1, 8'd69);
      for (int k = 0; k < 64; k++) send_word(32'h0000_1000 + 32'(k));
      chk("t3_rdy_full", 64'(word_rdy_o), 64'd0);
      word_vld_i = 1'b1; word_i = 32'h0000_1040;
      tick(); tick(); tick();
      chk("t3_rdy_held", 64'(word_rdy_o), 64'd0);
      word_vld_i = 1'b0;
      for (int k = 0; k < 8; k++) pop_ckn("t3_pop_early", {1'b0, 32'h0000_1000 + 32'(k)});
      chk("t3_rdy_resume", 64'(word_rdy_o), 64'd1);
      for (int k = 64; k < 70; k++) send_word(32'h0000_1000 + 32'(k));
      chk("t3_busy_done", 64'(busy_o), 64'd0);
      for (int k = 8; k < 70; k++) pop_ckn("t3_pop", {(k == 69), 32'h0000_1000 + 32'(k)});
      chk("t3_empty", 64'(ckn_ad_avail_o), 64'd0);
      pop_info("t3_info", 10'h345);
      chk("t3_trig", 64'(trig_cnt), 64'd3);

      // Concurrent push and pop at full rate, 256-word frame
      do_start(32'd1);
      send_hdr(1'b0, 1'b0, 8'hFF);
      pushed = 0; cyc = 0; maxocc = 0;
      while ((pushed < 256 || q.size() > 0) && cyc < 700) begin
         word_vld_i     = (pushed < 256);
         word_i         = 32'hA500_0000 | 32'(pushed);
         ckn_ad_fetch_i = ckn_ad_avail_o;
         do_push        = word_vld_i && (word_rdy_o === 1'b1);
         do_pop         = ckn_ad_fetch_i;
         tick();
         if (do_pop) begin
            chk("t4_model_nonempty", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("t4_data", 64'(ckn_data_o), 64'(e));
            end
         end
         if (do_push) begin
            q.push_back({(pushed == 255), 32'hA500_0000 | 32'(pushed)});
            pushed++;
         end
         if (q.size() > maxocc) maxocc = q.size();
         cyc++;
      end
      word_vld_i = 1'b0; ckn_ad_fetch_i = 1'b0;
      chk("t4_pushed", 64'(pushed), 64'd256);
      chk("t4_occ_bounded", 64'(maxocc <= 2), 64'd1);
      chk("t4_busy_done", 64'(busy_o), 64'd0);
      chk("t4_err", 64'(err_o), 64'd0);
      pop_info("t4_info", 10'h0FF);
      chk("t4_trig", 64'(trig_cnt), 64'd4);

      // Pop on empty CKN FIFO sets the sticky error and holds data
      pop_ckn("t5_hold", {1'b1, 32'hA500_00FF});
      chk("t5_err_set", 64'(err_o), 64'd1);
      tick();
      chk("t5_err_sticky", 64'(err_o), 64'd1);
      do_start(32'd1);
      chk("t5_err_clr", 64'(err_o), 64'd0);
      send_hdr(1'b0, 1'b0, 8'd0);
      send_word(32'h5A5A_5A5A);
      pop_info("t5_info", 10'h000);
      pop_ckn("t5_word", {1'b1, 32'h5A5A_5A5A});
      chk("t5_trig", 64'(trig_cnt), 64'd5);

      // Reset in mid-frame, then a fresh job
      do_start(32'd2);
      send_hdr(1'b0, 1'b1, 8'd3);
      send_word(32'hDEAD_0001);
      send_word(32'hDEAD_0002);
      iRst = 1'b1;
      tick(); tick();
      chk("t6_avail", 64'({ckn_ad_avail_o, wr_info_avail_o}), 64'd0);
      chk("t6_busy", 64'(busy_o), 64'd0);
      chk("t6_data", 64'(ckn_data_o), 64'd0);
      iRst = 1'b0;
      tick();
      tc0 = trig_cnt;
      do_start(32'd1);
      chk("t6_busy_new", 64'(busy_o), 64'd1);
      send_hdr(1'b0, 1'b0, 8'd1);
      send_word(32'h1234_0000);
      send_word(32'h1234_0001);
      tick();
      chk("t6_trig_new", 64'(trig_cnt), 64'(tc0 + 1));
      pop_info("t6_info", 10'h001);
      pop_ckn("t6_w0", {1'b0, 32'h1234_0000});
      pop_ckn("t6_w1", {1'b1, 32'h1234_0001});
      chk("t6_empty", 64'({ckn_ad_avail_o, wr_info_avail_o}), 64'd0);
      chk("t6_err", 64'(err_o), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
